// File: rtl/crc_stream_engine_pkg.sv
// Package for the streaming CRC-32 engine.
// Holds the default CRC-32/IEEE constants (reflected form) and the
// encoding of the engine's two-state beat FSM.
package crc_stream_engine_pkg;

    // Reflected CRC-32/IEEE generator polynomial (0x04C11DB7 bit-reversed)
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    // Register preset at the start of every frame
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Final XOR applied when the CRC is published
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    // S_IN   : waiting for a beat, s_ready high
    // S_PROC : chewing through the latched beat, BPC bytes per cycle
    typedef enum logic {
        S_IN   = 1'b0,
        S_PROC = 1'b1
    } state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational single-byte CRC-32 update (reflected, LSB-first).
// Ports:
//   i_crc  [31:0] CRC register value before the byte
//   i_byte [7:0]  data byte, bit 0 is shifted in first
//   o_crc  [31:0] CRC register value after all 8 bit steps
module crc32_byte_step
    import crc_stream_engine_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY_REFL
) (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_crc
);

    // Eight unrolled shift/feedback steps; feedback is the outgoing LSB
    // XORed with the incoming data bit.
    always_comb begin
        o_crc = i_crc;
        for (int b = 0; b < 8; b++) begin
            if (o_crc[0] ^ i_byte[b]) begin
                o_crc = (o_crc >> 1) ^ POLY;
            end else begin
                o_crc = o_crc >> 1;
            end
        end
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC-32 engine.
// Accepts a frame as a sequence of DATA_W-bit beats (valid/ready, first/last
// framing, byte keep on the last beat) and processes BPC bytes per clock.
// Each accepted beat occupies the engine for exactly K = NB/BPC cycles, so the
// result latency does not depend on keep.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_data     input word, lane 0 = bits [7:0] is consumed first
//   s_keep     byte enables, only honoured on the last beat
//   s_first    beat starts a new frame
//   s_last     beat closes the frame
//   s_valid    beat valid
//   s_ready    engine accepts a beat (depends on state only)
//   abort      synchronous frame discard
//   crc_out    final CRC, held until the next crc_valid
//   crc_valid  one-cycle result pulse
//   busy       frame open or beat being processed
module crc_stream_engine
    import crc_stream_engine_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          BPC    = 1,
    parameter logic [31:0] POLY   = CRC32_POLY_REFL,
    parameter logic [31:0] INIT   = CRC32_INIT,
    parameter logic [31:0] XOROUT = CRC32_XOROUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_first,
    input  logic                s_last,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                abort,
    output logic [31:0]         crc_out,
    output logic                crc_valid,
    output logic                busy
);

    localparam int NB  = DATA_W / 8;
    localparam int K   = NB / BPC;
    localparam int CW  = (K > 1) ? $clog2(K) : 1;
    localparam int SHW = BPC * 8;

    state_t             r_state;
    logic [DATA_W-1:0]  r_data;
    logic [NB-1:0]      r_keep;
    logic               r_last;
    logic               r_frame_open;
    logic [CW-1:0]      r_cyc_cnt;
    logic [31:0]        r_crc;
    logic [31:0]        r_crc_out;
    logic               r_crc_valid;

    logic [BPC:0][31:0]   w_chain;
    logic [BPC-1:0][31:0] w_step;
    logic [DATA_W-1:0]    w_data_nxt;
    logic [NB-1:0]        w_keep_nxt;
    logic                 w_last_cyc;
    logic [31:0]          w_next_crc;

    // The latched beat is shifted down by BPC lanes every cycle, so the
    // lanes being processed are always the lowest BPC lanes of r_data/r_keep.
    assign w_chain[0] = r_crc;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_lane
            crc32_byte_step #(
                .POLY (POLY)
            ) u_step (
                .i_crc  (w_chain[gi]),
                .i_byte (r_data[gi*8 +: 8]),
                .o_crc  (w_step[gi])
            );
            // A lane with keep=0 passes the CRC through untouched
            assign w_chain[gi+1] = r_keep[gi] ? w_step[gi] : w_chain[gi];
        end

        if (K > 1) begin : g_shift
            assign w_data_nxt = {{SHW{1'b0}}, r_data[DATA_W-1:SHW]};
            assign w_keep_nxt = {{BPC{1'b0}}, r_keep[NB-1:BPC]};
        end else begin : g_noshift
            assign w_data_nxt = r_data;
            assign w_keep_nxt = r_keep;
        end
    endgenerate

    assign w_next_crc = w_chain[BPC];
    assign w_last_cyc = (r_cyc_cnt == CW'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IN;
            r_data       <= '0;
            r_keep       <= '0;
            r_last       <= 1'b0;
            r_frame_open <= 1'b0;
            r_cyc_cnt    <= '0;
            r_crc        <= INIT;
            r_crc_out    <= 32'h0;
            r_crc_valid  <= 1'b0;
        end else begin
            r_crc_valid <= 1'b0;
            if (abort) begin
                // Discard everything in flight; crc_out keeps its last value
                r_state      <= S_IN;
                r_frame_open <= 1'b0;
                r_crc        <= INIT;
            end else begin
                case (r_state)
                    S_IN: begin
                        if (s_valid) begin
                            r_data    <= s_data;
                            r_keep    <= s_last ? s_keep : {NB{1'b1}};
                            r_last    <= s_last;
                            r_cyc_cnt <= '0;
                            // s_first mid-frame silently restarts the frame;
                            // a beat without an open frame also starts one
                            if (s_first || !r_frame_open) begin
                                r_crc <= INIT;
                            end
                            r_frame_open <= 1'b1;
                            r_state      <= S_PROC;
                        end
                    end
                    S_PROC: begin
                        r_crc     <= w_next_crc;
                        r_data    <= w_data_nxt;
                        r_keep    <= w_keep_nxt;
                        r_cyc_cnt <= r_cyc_cnt + CW'(1);
                        if (w_last_cyc) begin
                            r_state <= S_IN;
                            if (r_last) begin
                                r_crc_out    <= w_next_crc ^ XOROUT;
                                r_crc_valid  <= 1'b1;
                                r_frame_open <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IN;
                endcase
            end
        end
    end

    assign s_ready   = (r_state == S_IN);
    assign busy      = r_frame_open | (r_state == S_PROC);
    assign crc_out   = r_crc_out;
    assign crc_valid = r_crc_valid;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine. Three instances are built
// (32b/BPC=1, 32b/BPC=4, 64b/BPC=2); "sel" routes stimulus to one of them.
module tb_crc_stream_engine;

    localparam logic [31:0] M_POLY   = 32'hEDB88320;
    localparam logic [31:0] M_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] M_XOROUT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tb_data;
    logic [7:0]  tb_keep;
    logic        tb_first, tb_last, tb_valid, tb_abort;
    logic [1:0]  sel;

    logic [2:0]  rdy, cv, bsy;
    logic [31:0] crco0, crco1, crco2;

    logic        cur_ready, cur_cv, cur_busy;
    logic [31:0] cur_crc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crc_stream_engine #(.DATA_W(32), .BPC(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .s_data(tb_data[31:0]), .s_keep(tb_keep[3:0]),
        .s_first(tb_first), .s_last(tb_last), .s_valid(tb_valid && sel == 2'd0),
        .s_ready(rdy[0]), .abort(tb_abort && sel == 2'd0),
        .crc_out(crco0), .crc_valid(cv[0]), .busy(bsy[0]));

    crc_stream_engine #(.DATA_W(32), .BPC(4)) dut_b4 (
        .clk(clk), .rst_n(rst_n), .s_data(tb_data[31:0]), .s_keep(tb_keep[3:0]),
        .s_first(tb_first), .s_last(tb_last), .s_valid(tb_valid && sel == 2'd1),
        .s_ready(rdy[1]), .abort(tb_abort && sel == 2'd1),
        .crc_out(crco1), .crc_valid(cv[1]), .busy(bsy[1]));

    crc_stream_engine #(.DATA_W(64), .BPC(2)) dut_w64 (
        .clk(clk), .rst_n(rst_n), .s_data(tb_data), .s_keep(tb_keep),
        .s_first(tb_first), .s_last(tb_last), .s_valid(tb_valid && sel == 2'd2),
        .s_ready(rdy[2]), .abort(tb_abort && sel == 2'd2),
        .crc_out(crco2), .crc_valid(cv[2]), .busy(bsy[2]));

    assign cur_ready = rdy[sel];
    assign cur_cv    = cv[sel];
    assign cur_busy  = bsy[sel];
    assign cur_crc   = (sel == 2'd0) ? crco0 : (sel == 2'd1) ? crco1 : crco2;

    function automatic int cur_k();
        return (sel == 2'd1) ? 1 : 4;
    endfunction

    function automatic int cur_nb();
        return (sel == 2'd2) ? 8 : 4;
    endfunction

    // ---------------- reference model: byte-wise table CRC ----------------
    logic [31:0] crc_tab [256];
    logic [63:0] fr_data [$];
    logic [7:0]  fr_keep_last;

    task automatic build_tab();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ M_POLY) : (c >> 1);
            crc_tab[n] = c;
        end
    endtask

    function automatic logic [31:0] model_crc(input int nb);
        logic [31:0] c;
        logic [7:0]  byt;
        logic [7:0]  idx;
        c = M_INIT;
        for (int b = 0; b < fr_data.size(); b++) begin
            for (int l = 0; l < nb; l++) begin
                if (b != fr_data.size() - 1 || fr_keep_last[l]) begin
                    byt = fr_data[b][l*8 +: 8];
                    idx = c[7:0] ^ byt;
                    c   = crc_tab[idx] ^ (c >> 8);
                end
            end
        end
        return c ^ M_XOROUT;
    endfunction

    // ---------------- checking / driving helpers ----------------
    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic first, input logic last);
        int w = 0;
        @(negedge clk);
        while (cur_ready !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w >= 64) begin
            check("ready_timeout", 64'(cur_ready), 64'd1);
            return;
        end
        tb_data  = d;
        tb_keep  = k;
        tb_first = first;
        tb_last  = last;
        tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
    endtask

    // Called right after the accepting edge E. Counts the cycles with
    // s_ready low (must be K), then checks the pulse and result.
    task automatic wait_done(input string nm, input logic last, input logic [31:0] exp);
        int low = 0;
        @(negedge clk);
        while (cur_ready !== 1'b1 && low < 64) begin
            low++;
            @(negedge clk);
        end
        check({nm, "_latency"}, 64'(low), 64'(cur_k()));
        check({nm, "_valid"}, 64'(cur_cv), 64'(last));
        check({nm, "_busy"}, 64'(cur_busy), 64'(!last));
        if (last) begin
            check({nm, "_crc"}, 64'(cur_crc), 64'(exp));
            @(negedge clk);
            check({nm, "_pulse1"}, 64'(cur_cv), 64'd0);
        end
    endtask

    task automatic run_frame(input string nm, input logic [31:0] exp,
                             input int maxgap, input logic no_first);
        int last_i = fr_data.size() - 1;
        for (int b = 0; b <= last_i; b++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            send_beat(fr_data[b], (b == last_i) ? fr_keep_last : 8'hFF,
                      (b == 0) && !no_first, b == last_i);
            wait_done(nm, b == last_i, exp);
        end
        $display("[TB] %s sel=%0d beats=%0d crc=%h exp=%h", nm, sel, fr_data.size(), cur_crc, exp);
    endtask

    task automatic load_t1();
        fr_data.delete();
        fr_data.push_back(64'h34333231);
        fr_data.push_back(64'h38373635);
        fr_data.push_back(64'h00000039);
        fr_keep_last = 8'h01;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [1:0]  sel;
        int          nbeats;
        logic [63:0] d0, d1, d2;
        logic [7:0]  klast;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input string nm, input logic [1:0] s, input int n,
                           input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                           input logic [7:0] k, input logic [31:0] e);
        vec_t v;
        v.name = nm; v.sel = s; v.nbeats = n;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.klast = k; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; tb_data = '0; tb_keep = '0; tb_first = 1'b0; tb_last = 1'b0;
        tb_valid = 1'b0; tb_abort = 1'b0; sel = 2'd0;
        build_tab();

        add_vec("t1_b1",     2'd0, 3, 64'h34333231, 64'h38373635, 64'h39, 8'h01, 32'hCBF43926);
        add_vec("zero4_b1",  2'd0, 1, 64'h0,        64'h0,        64'h0,  8'h0F, 32'h2144DF1C);
        add_vec("a_b1",      2'd0, 1, 64'h61,       64'h0,        64'h0,  8'h01, 32'hE8B7BE43);
        add_vec("keep0_one", 2'd0, 1, 64'hDEADBEEF, 64'h0,        64'h0,  8'h00, 32'h00000000);
        add_vec("keep0_end", 2'd0, 2, 64'h34333231, 64'h12345678, 64'h0,  8'h00, 32'h9BE3E0A3);
        add_vec("t1_b4",     2'd1, 3, 64'h34333231, 64'h38373635, 64'h39, 8'h01, 32'hCBF43926);
        add_vec("zero4_b4",  2'd1, 1, 64'h0,        64'h0,        64'h0,  8'h0F, 32'h2144DF1C);
        add_vec("a_b4",      2'd1, 1, 64'h61,       64'h0,        64'h0,  8'h01, 32'hE8B7BE43);
        add_vec("t1_w64",    2'd2, 2, 64'h3837363534333231, 64'h39, 64'h0, 8'h01, 32'hCBF43926);
        add_vec("a_w64",     2'd2, 1, 64'h61,       64'h0,        64'h0,  8'h01, 32'hE8B7BE43);

        // Reset values on every instance
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check("rst_ready", 64'(cur_ready), 64'd1);
            check("rst_busy",  64'(cur_busy),  64'd0);
            check("rst_valid", 64'(cur_cv),    64'd0);
            check("rst_crc",   64'(cur_crc),   64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven known-answer frames
        for (int i = 0; i < vecs.size(); i++) begin
            sel = vecs[i].sel;
            fr_data.delete();
            fr_data.push_back(vecs[i].d0);
            if (vecs[i].nbeats > 1) fr_data.push_back(vecs[i].d1);
            if (vecs[i].nbeats > 2) fr_data.push_back(vecs[i].d2);
            fr_keep_last = vecs[i].klast;
            run_frame(vecs[i].name, vecs[i].exp, 0, 1'b0);
        end

        // Abort during the second beat: no result, crc_out retained
        sel = 2'd0;
        fr_data.delete(); fr_data.push_back(64'h61); fr_keep_last = 8'h01;
        run_frame("pre_abort", 32'hE8B7BE43, 0, 1'b0);
        send_beat(64'h34333231, 8'hF, 1'b1, 1'b0);
        wait_done("ab_b0", 1'b0, 32'h0);
        send_beat(64'h38373635, 8'hF, 1'b0, 1'b0);
        tb_abort = 1'b1;
        @(posedge clk);
        #1 tb_abort = 1'b0;
        begin
            int pulses = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (cur_cv) pulses++;
            end
            check("abort_no_valid", 64'(pulses), 64'd0);
        end
        check("abort_ready", 64'(cur_ready), 64'd1);
        check("abort_busy",  64'(cur_busy),  64'd0);
        check("abort_crc_hold", 64'(cur_crc), 64'hE8B7BE43);
        $display("[TB] abort mid-frame crc_out=%h", cur_crc);

        // Beat presented together with abort in S_IN is ignored
        @(negedge clk);
        tb_data = 64'h0; tb_keep = 8'hF; tb_first = 1'b1; tb_last = 1'b1;
        tb_valid = 1'b1; tb_abort = 1'b1;
        @(posedge clk);
        #1 begin tb_valid = 1'b0; tb_abort = 1'b0; end
        @(negedge clk);
        check("abort_in_busy",  64'(cur_busy),  64'd0);
        check("abort_in_ready", 64'(cur_ready), 64'd1);
        $display("[TB] abort with beat in S_IN busy=%0b", cur_busy);

        // Beat without s_first and no open frame starts a fresh frame
        fr_data.delete(); fr_data.push_back(64'h61); fr_keep_last = 8'h01;
        run_frame("nofirst", 32'hE8B7BE43, 0, 1'b1);
        load_t1();
        run_frame("post_abort_t1", 32'hCBF43926, 0, 1'b0);

        // s_first mid-frame discards the open frame
        send_beat(64'hFFFFFFFF, 8'hF, 1'b1, 1'b0);
        wait_done("discard_b0", 1'b0, 32'h0);
        load_t1();
        run_frame("restart_t1", 32'hCBF43926, 0, 1'b0);

        // Reset mid-frame with s_valid held high
        send_beat(64'h34333231, 8'hF, 1'b1, 1'b0);
        rst_n = 1'b0; tb_valid = 1'b1; tb_first = 1'b1; tb_last = 1'b0;
        #2;
        check("midrst_ready", 64'(cur_ready), 64'd1);
        check("midrst_valid", 64'(cur_cv),    64'd0);
        check("midrst_crc",   64'(cur_crc),   64'd0);
        check("midrst_busy",  64'(cur_busy),  64'd0);
        $display("[TB] reset mid-frame crc_out=%h ready=%0b", cur_crc, cur_ready);
        @(negedge clk);
        tb_valid = 1'b0;
        rst_n = 1'b1;
        load_t1();
        run_frame("after_rst_t1", 32'hCBF43926, 0, 1'b0);

        // Random frames with random gaps against the model
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int f = 0; f < 15; f++) begin
                int nbeats, cnt;
                nbeats = $urandom_range(4, 1);
                fr_data.delete();
                for (int b = 0; b < nbeats; b++) fr_data.push_back({$urandom, $urandom});
                cnt = $urandom_range(cur_nb(), 0);
                fr_keep_last = 8'((9'd1 << cnt) - 9'd1);
                run_frame("rand", model_crc(cur_nb()), 3, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
